// File: rtl/cache_ctrl_nway_pkg.sv
// Shared definitions for the N-way cache control FSM: state codes, policy
// constants and elaboration-time width helpers.
package cache_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_WTHRU  = 3'd3;
  localparam logic [2:0] ST_EVICT  = 3'd4;
  localparam logic [2:0] ST_FILL   = 3'd5;
  localparam logic [2:0] ST_UPDATE = 3'd6;
  localparam logic [2:0] ST_ACK    = 3'd7;

  localparam bit POLICY_WB = 1'b1;
  localparam bit POLICY_WT = 1'b0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A one-beat line still needs a 1-bit beat port.
  function automatic int beat_w(input int line_words);
    return (clog2(line_words) < 1) ? 1 : clog2(line_words);
  endfunction

endpackage

// File: rtl/cache_ctrl_nway_repl_ptr_array.sv
// Per-set round-robin replacement pointers; one read port, one increment port.
module repl_ptr_array
  import cache_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 16,
  localparam int WW = clog2(WAYS),
  localparam int SW = clog2(SETS)
)(
  input  logic          clk,
  input  logic          reset,
  input  logic [SW-1:0] rd_index,
  output logic [WW-1:0] rd_ptr,
  input  logic          inc,
  input  logic [SW-1:0] inc_index
);

  logic [SETS-1:0][WW-1:0] ptr;

  // WAYS is a power of two, so the natural WW-bit wrap is the modulo.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (inc) begin
      for (int s = 0; s < SETS; s++)
        if (inc_index == SW'(s)) ptr[s] <= ptr[s] + 1'b1;
    end
  end

  assign rd_ptr = ptr[rd_index];

endmodule

// File: rtl/cache_ctrl_nway.sv
// Sequencer for an N-way set-associative cache: lookup, write, write-through,
// multi-beat evict/fill and per-set round-robin victim selection.
module cache_ctrl_nway
  import cache_pkg::*;
#(
  parameter int WAYS       = 4,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter bit WRITE_BACK = POLICY_WB,
  localparam int WW = clog2(WAYS),
  localparam int SW = clog2(SETS),
  localparam int BW = beat_w(LINE_WORDS)
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          sys_rd,
  input  logic          sys_wr,
  input  logic [SW-1:0] sys_index,
  input  logic          hit,
  input  logic [WW-1:0] hit_way,
  input  logic          victim_dirty,
  input  logic          ram_ack,
  output logic          ram_avalid,
  output logic          ram_wr,
  output logic [BW-1:0] ram_beat,
  output logic          wr,
  output logic          wr_tag,
  output logic          set_dirty,
  output logic          select_data,
  output logic [WW-1:0] way_sel,
  output logic          sys_ack
);

  logic [2:0]    state, nxt;
  logic          op_wr;
  logic [SW-1:0] index;
  logic [WW-1:0] way_q, way_lookup, rptr;
  logic [BW-1:0] beat;
  logic          last_beat, in_burst;

  repl_ptr_array #(.WAYS(WAYS), .SETS(SETS)) u_repl (
    .clk       (clk),
    .reset     (reset),
    .rd_index  (index),
    .rd_ptr    (rptr),
    .inc       (state == ST_UPDATE),
    .inc_index (index)
  );

  assign way_lookup = hit ? hit_way : rptr;
  assign last_beat  = (beat == BW'(LINE_WORDS - 1));
  assign in_burst   = (state == ST_EVICT) || (state == ST_FILL);

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (sys_rd ^ sys_wr) nxt = ST_LOOKUP;
      ST_LOOKUP: begin
        if (hit)                       nxt = op_wr ? ST_WRITE : ST_ACK;
        else if (op_wr && !WRITE_BACK) nxt = ST_WTHRU;
        else if (WRITE_BACK && victim_dirty) nxt = ST_EVICT;
        else                           nxt = ST_FILL;
      end
      ST_WRITE:  nxt = WRITE_BACK ? ST_ACK : ST_WTHRU;
      ST_WTHRU:  if (ram_ack) nxt = ST_ACK;
      ST_EVICT:  if (ram_ack && last_beat) nxt = ST_FILL;
      ST_FILL:   if (ram_ack && last_beat) nxt = ST_UPDATE;
      // After a fill the retried lookup is a guaranteed hit.
      ST_UPDATE: nxt = (sys_rd || sys_wr) ? ST_LOOKUP : ST_IDLE;
      ST_ACK:    if (!sys_rd && !sys_wr) nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      op_wr <= 1'b0;
      index <= '0;
      way_q <= '0;
      beat  <= '0;
    end else begin
      state <= nxt;
      if (state == ST_IDLE && (sys_rd ^ sys_wr)) begin
        op_wr <= sys_wr;
        index <= sys_index;
      end
      if (state == ST_LOOKUP) way_q <= way_lookup;
      if (in_burst && ram_ack) beat <= last_beat ? '0 : beat + 1'b1;
    end
  end

  assign ram_avalid  = (state == ST_WTHRU) || in_burst;
  assign ram_wr      = (state == ST_WTHRU) || (state == ST_EVICT);
  assign ram_beat    = beat;
  assign wr          = (state == ST_WRITE) || ((state == ST_FILL) && ram_ack);
  assign wr_tag      = (state == ST_UPDATE);
  assign set_dirty   = (state == ST_WRITE) && WRITE_BACK;
  assign select_data = (state == ST_FILL);
  assign way_sel     = (state == ST_LOOKUP) ? way_lookup : way_q;
  assign sys_ack     = (state == ST_ACK);

endmodule
